apple_spawn_ctrl: RTL and testbench
===================================

APPLE_SPAWN_CTRL -- requirements
Module: apple_spawn_ctrl

Interface
REQ-001 Parameter H_LOGIC_WIDTH, 5: width of logical X coordinate.
REQ-002 Parameter V_LOGIC_WIDTH, 5: width of logical Y coordinate.
REQ-003 Parameter H_LOGIC_MAX, 5'd31: largest legal X.
REQ-004 Parameter V_LOGIC_MAX, 5'd23: largest legal Y.
REQ-005 Parameter MAX_RETRY, 4'd15: rejected candidates allowed before giving up.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 eat  input  1  request a new apple; sampled on the rising edge.
REQ-009 length  input  10  snake segment count; valid body indices are 0..length-1, with 0 the head.
REQ-010 cand_x  input  H_LOGIC_WIDTH  candidate X from the external random source.
REQ-011 cand_y  input  V_LOGIC_WIDTH  candidate Y from the external random source.
REQ-012 body_rd  output  1  body memory read strobe.
REQ-013 body_addr  output  10  body segment index being read.
REQ-014 body_x  input  H_LOGIC_WIDTH  segment X; valid the cycle after body_rd.
REQ-015 body_y  input  V_LOGIC_WIDTH  segment Y; valid the cycle after body_rd.
REQ-016 appleX  output  H_LOGIC_WIDTH  committed apple X, registered.
REQ-017 appleY  output  V_LOGIC_WIDTH  committed apple Y, registered.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 spawned  output  1  one-cycle pulse; a new apple has been committed.
REQ-020 fail  output  1  one-cycle pulse; retry limit reached and the apple is unchanged.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, SAMPLE, READ, CHECK, COMMIT.
REQ-022 IDLE SHALL go to SAMPLE on eat=1 and clear the retry counter; eat SHALL be ignored in every other state.
REQ-023 SAMPLE SHALL register cand_x/cand_y and latch length into an internal len register; later changes to length SHALL NOT affect the current scan.
REQ-024 SAMPLE range check:
  - cand_x > H_LOGIC_MAX or cand_y > V_LOGIC_MAX: reject the candidate.
  - candidate in range and latched length = 0: go to COMMIT.
  - otherwise: go to READ with index 0.
REQ-025 READ SHALL drive body_rd=1 and body_addr=index, then go to CHECK; body_rd SHALL be 0 in all other states and body_addr SHALL hold its value.
REQ-026 In CHECK:
  - body_x/body_y equal to the candidate: reject the candidate.
  - no match and index = len-1: go to COMMIT.
  - no match otherwise: increment index and go to READ.
REQ-027 Rejection (from SAMPLE or CHECK):
  - retry counter = MAX_RETRY: pulse fail, leave appleX/appleY unchanged, go to IDLE.
  - otherwise: increment the retry counter and go to SAMPLE.
REQ-028 Entry into COMMIT SHALL load appleX/appleY from the candidate on the same edge; spawned SHALL be 1 for exactly the COMMIT cycle; the next state SHALL be IDLE.
REQ-029 Latency: for a first-try accept with latched length L and eat sampled at edge 0, spawned SHALL be high after edge 2L+2 (L=0: after edge 2).
REQ-030 The index counter SHALL be 10 bits; L=1023 SHALL scan indices 0..1022 without wrap.
REQ-031 spawned and fail SHALL never be high in the same cycle.
REQ-032 A new eat SHALL be accepted on the edge that returns the FSM to IDLE only if the FSM is already in IDLE; back-to-back requests therefore need at least one IDLE cycle.

Reset
REQ-033 While rst=0 the block SHALL asynchronously force:
  - state IDLE; busy, spawned, fail and body_rd to 0;
  - body_addr, index and retry counter to 0;
  - appleX=15 and appleY=15.
REQ-034 Reset asserted mid-scan SHALL abort the scan with no spawned or fail pulse.
REQ-035 Operation SHALL resume on the first rising edge after rst returns to 1.

Verification
REQ-036 Bench SHALL cover:
  - Reset: rst=0 -> appleX=15, appleY=15, busy=0, body_rd=0.
  - L=3, body={(5,5),(5,6),(5,7)}, cand=(10,10), eat pulse -> body_addr steps 0,1,2; spawned after edge 8; apple=(10,10).
  - Range reject: cand=(31,24) on the first SAMPLE, then (3,4) -> one retry; apple=(3,4); no fail.
  - Retry limit: cand held at the head position (5,5), MAX_RETRY=15 -> 16 rejections; fail pulses once; apple unchanged; busy drops.
  - L=0, cand=(0,0) -> spawned after edge 2 with no body_rd; length changed to 7 mid-scan in a second run -> scan still ends at the latched L.
  - rst=0 during CHECK of index 1 -> immediate IDLE; no spawned; apple=(15,15).

Source files
------------

// File: rtl/apple_spawn_ctrl.sv
// Apple placement controller: samples a random candidate cell, scans the snake body
// for a collision, and commits the apple or retries up to MAX_RETRY times.
module apple_spawn_ctrl #(
  parameter int unsigned              H_LOGIC_WIDTH = 5,
  parameter int unsigned              V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = 5'd23,
  parameter logic [3:0]               MAX_RETRY     = 4'd15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eat,
  input  logic [9:0]               length,
  input  logic [H_LOGIC_WIDTH-1:0] cand_x,
  input  logic [V_LOGIC_WIDTH-1:0] cand_y,
  output logic                     body_rd,
  output logic [9:0]               body_addr,
  input  logic [H_LOGIC_WIDTH-1:0] body_x,
  input  logic [V_LOGIC_WIDTH-1:0] body_y,
  output logic [H_LOGIC_WIDTH-1:0] appleX,
  output logic [V_LOGIC_WIDTH-1:0] appleY,
  output logic                     busy,
  output logic                     spawned,
  output logic                     fail
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    READ   = 3'd2,
    CHECK  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [H_LOGIC_WIDTH-1:0] APPLE_X_RST = H_LOGIC_WIDTH'(15);
  localparam logic [V_LOGIC_WIDTH-1:0] APPLE_Y_RST = V_LOGIC_WIDTH'(15);

  state_t                     state_r, state_s;
  logic                       req_r;
  logic [H_LOGIC_WIDTH-1:0]   cand_x_r;
  logic [V_LOGIC_WIDTH-1:0]   cand_y_r;
  logic [9:0]                 len_r;
  logic [9:0]                 index_r, index_s;
  logic [3:0]                 retry_r, retry_s;
  logic [H_LOGIC_WIDTH-1:0]   apple_x_r, apple_x_s;
  logic [V_LOGIC_WIDTH-1:0]   apple_y_r, apple_y_s;
  logic                       busy_r, spawned_r, fail_r, body_rd_r;
  logic [9:0]                 body_addr_r;
  logic                       in_range_s, reject_s, fail_s;

  // Wide compare so a maximum equal to the full coordinate range stays well-formed.
  assign in_range_s = (32'(cand_x) <= 32'(H_LOGIC_MAX)) && (32'(cand_y) <= 32'(V_LOGIC_MAX));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, scan index, retry count and apple update.
  always_comb begin
    state_s   = state_r;
    index_s   = index_r;
    retry_s   = retry_r;
    apple_x_s = apple_x_r;
    apple_y_s = apple_y_r;
    reject_s  = 1'b0;
    fail_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_r) begin
          state_s = SAMPLE;
          retry_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SAMPLE: begin
        if (!in_range_s) begin
          reject_s = 1'b1;
        end else if (length == 10'd0) begin
          state_s   = COMMIT;
          apple_x_s = cand_x;
          apple_y_s = cand_y;
        end else begin
          state_s = READ;
          index_s = 10'd0;
        end
      end
      READ: begin
        state_s = CHECK;
      end
      CHECK: begin
        if ((body_x == cand_x_r) && (body_y == cand_y_r)) begin
          reject_s = 1'b1;
        end else if (index_r == (len_r - 10'd1)) begin
          state_s   = COMMIT;
          apple_x_s = cand_x_r;
          apple_y_s = cand_y_r;
        end else begin
          state_s = READ;
          index_s = index_r + 10'd1;
        end
      end
      COMMIT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A rejection either retries with a fresh candidate or gives up.
    if (reject_s) begin
      if (retry_r == MAX_RETRY) begin
        fail_s  = 1'b1;
        state_s = IDLE;
      end else begin
        retry_s = retry_r + 4'd1;
        state_s = SAMPLE;
      end
    end else begin
      fail_s = 1'b0;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_r       <= 1'b0;
      cand_x_r    <= '0;
      cand_y_r    <= '0;
      len_r       <= 10'd0;
      index_r     <= 10'd0;
      retry_r     <= 4'd0;
      apple_x_r   <= APPLE_X_RST;
      apple_y_r   <= APPLE_Y_RST;
      busy_r      <= 1'b0;
      spawned_r   <= 1'b0;
      fail_r      <= 1'b0;
      body_rd_r   <= 1'b0;
      body_addr_r <= 10'd0;
    end else begin
      // The request flag is only armed while idle, so eat is ignored mid-scan.
      if (state_r == IDLE) begin
        req_r <= eat & ~req_r;
      end else begin
        req_r <= 1'b0;
      end
      if (state_r == SAMPLE) begin
        cand_x_r <= cand_x;
        cand_y_r <= cand_y;
        len_r    <= length;
      end else begin
        cand_x_r <= cand_x_r;
        cand_y_r <= cand_y_r;
        len_r    <= len_r;
      end
      index_r   <= index_s;
      retry_r   <= retry_s;
      apple_x_r <= apple_x_s;
      apple_y_r <= apple_y_s;
      busy_r    <= (state_s != IDLE);
      spawned_r <= (state_s == COMMIT);
      fail_r    <= fail_s;
      body_rd_r <= (state_s == READ);
      if (state_s == READ) begin
        body_addr_r <= index_s;
      end else begin
        body_addr_r <= body_addr_r;
      end
    end
  end

  assign appleX    = apple_x_r;
  assign appleY    = apple_y_r;
  assign busy      = busy_r;
  assign spawned   = spawned_r;
  assign fail      = fail_r;
  assign body_rd   = body_rd_r;
  assign body_addr = body_addr_r;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Scoreboard bench for apple_spawn_ctrl: a timing/outcome model predicts body reads and
// the spawn/fail event of each request; a forked monitor compares what the DUT presents.
module tb_apple_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       eat;
  logic [9:0] length;
  logic [4:0] cand_x, cand_y;
  logic       body_rd;
  logic [9:0] body_addr;
  logic [4:0] body_x, body_y;
  logic [4:0] appleX, appleY;
  logic       busy, spawned, fail;

  typedef struct {
    bit is_fail;
    int cyc;
    int ax;
    int ay;
  } ev_t;

  ev_t ev_q[$];
  int  addr_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  mem_x[1024];
  int  mem_y[1024];
  int  cxs[16];
  int  cys[16];
  int  model_ax, model_ay;

  always #5 clk = ~clk;

  apple_spawn_ctrl dut (
    .clk(clk), .rst(rst), .eat(eat), .length(length),
    .cand_x(cand_x), .cand_y(cand_y),
    .body_rd(body_rd), .body_addr(body_addr),
    .body_x(body_x), .body_y(body_y),
    .appleX(appleX), .appleY(appleY),
    .busy(busy), .spawned(spawned), .fail(fail)
  );

  // Body memory: one-cycle read latency, junk data when not read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (body_rd === 1'b1) begin
      body_x <= 5'(mem_x[body_addr]);
      body_y <= 5'(mem_y[body_addr]);
    end else begin
      body_x <= 5'($urandom);
      body_y <= 5'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (body_rd === 1'b1) begin
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got addr %0d expected no read", body_addr);
          end else begin
            chk("body_addr", body_addr, addr_q.pop_front());
          end
        end
        if (spawned === 1'b1 || fail === 1'b1) begin
          chk("pulse_exclusive", spawned & fail, 0);
          if (ev_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got spawned=%0d fail=%0d expected none", spawned, fail);
          end else begin
            e = ev_q.pop_front();
            chk("fail_pulse", fail, e.is_fail);
            chk("spawned_pulse", spawned, !e.is_fail);
            chk("event_cycle", cyc, e.cyc);
            chk("appleX", appleX, e.ax);
            chk("appleY", appleY, e.ay);
          end
        end
      end
    end
  endtask

  task automatic fill_body(input int n);
    for (int k = 0; k < 1024; k++) begin
      mem_x[k] = $urandom_range(0, 31);
      mem_y[k] = $urandom_range(0, 23);
    end
  endtask

  // Predict the request outcome from the placement rules, then drive it cycle by cycle.
  task automatic run_req(input int L);
    int s_cyc[16];
    int n_att, t, base, last;
    bit ok;
    ev_t e;
    t = 1;
    ok = 1'b0;
    n_att = 0;
    last = 0;
    for (int j = 0; j < 16; j++) begin
      int scanned;
      bit rej;
      s_cyc[j] = t;
      n_att = j + 1;
      last = j;
      rej = 1'b0;
      scanned = 0;
      if (cys[j] > 23 || cxs[j] > 31) begin
        rej = 1'b1;
      end else begin
        scanned = L;
        for (int k = 0; k < L; k++) begin
          if (mem_x[k] == cxs[j] && mem_y[k] == cys[j]) begin
            rej = 1'b1;
            scanned = k + 1;
            break;
          end
        end
      end
      for (int k = 0; k < scanned; k++) addr_q.push_back(k);
      t = t + 1 + 2 * scanned;
      if (!rej) begin
        ok = 1'b1;
        break;
      end
    end

    @(negedge clk);
    eat = 1'b1;
    length = 10'($urandom);
    cand_x = 5'($urandom);
    cand_y = 5'($urandom);
    base = cyc + 1;
    if (ok) begin
      model_ax = cxs[last];
      model_ay = cys[last];
    end
    e.is_fail = !ok;
    e.cyc = base + t;
    e.ax = model_ax;
    e.ay = model_ay;
    ev_q.push_back(e);

    for (int c = 0; c <= t; c++) begin
      int j;
      j = -1;
      @(negedge clk);
      for (int i = 0; i < n_att; i++) begin
        if (s_cyc[i] == c) j = i;
      end
      eat = (c >= 1 && c < t) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (j >= 0) begin
        cand_x = 5'(cxs[j]);
        cand_y = 5'(cys[j]);
        length = 10'(L);
      end else begin
        cand_x = 5'($urandom);
        cand_y = 5'($urandom);
        length = 10'($urandom);
      end
    end
    eat = 1'b0;
    for (int w = 0; w < 20 && ev_q.size() != 0; w++) @(negedge clk);
    chk("pending_events", ev_q.size(), 0);
    chk("pending_reads", addr_q.size(), 0);
    ev_q.delete();
    addr_q.delete();
    @(negedge clk);
    #1;
    chk("busy_after", busy, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic set_cands(input int x0, input int y0, input int x, input int y);
    cxs[0] = x0;
    cys[0] = y0;
    for (int j = 1; j < 16; j++) begin
      cxs[j] = x;
      cys[j] = y;
    end
  endtask

  task automatic snake3();
    fill_body(3);
    mem_x[0] = 5; mem_y[0] = 5;
    mem_x[1] = 5; mem_y[1] = 6;
    mem_x[2] = 5; mem_y[2] = 7;
  endtask

  initial begin
    rst = 1'b0;
    eat = 1'b0;
    length = 10'd0;
    cand_x = 5'd0;
    cand_y = 5'd0;
    model_ax = 15;
    model_ay = 15;
    fill_body(0);
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_appleX", appleX, 15);
    chk("rst_appleY", appleY, 15);
    chk("rst_busy", busy, 0);
    chk("rst_body_rd", body_rd, 0);
    chk("rst_spawned", spawned, 0);
    chk("rst_fail", fail, 0);
    chk("rst_body_addr", body_addr, 0);
    rst = 1'b1;
    @(negedge clk);

    snake3();
    set_cands(10, 10, 10, 10);
    run_req(3);
    set_cands(31, 24, 3, 4);
    run_req(3);
    set_cands(5, 5, 5, 5);
    run_req(3);
    set_cands(0, 0, 0, 0);
    run_req(0);
    fill_body(5);
    set_cands(30, 1, 30, 1);
    mem_x[4] = 30; mem_y[4] = 1;
    cxs[1] = 29; cys[1] = 22;
    run_req(5);

    for (int r = 0; r < 30; r++) begin
      int L;
      L = $urandom_range(0, 8);
      fill_body(L);
      for (int j = 0; j < 16; j++) begin
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
          cxs[j] = $urandom_range(0, 31);
          cys[j] = $urandom_range(24, 31);
        end else if (sel == 1 && L > 0) begin
          int k;
          k = $urandom_range(0, L - 1);
          cxs[j] = mem_x[k];
          cys[j] = mem_y[k];
        end else begin
          cxs[j] = $urandom_range(0, 31);
          cys[j] = $urandom_range(0, 23);
        end
      end
      run_req(L);
    end

    for (int k = 0; k < 1024; k++) begin
      mem_x[k] = 1;
      mem_y[k] = 1;
    end
    set_cands(2, 2, 2, 2);
    run_req(1023);

    // Reset during the CHECK of index 1 aborts the scan silently.
    snake3();
    @(negedge clk);
    eat = 1'b1;
    addr_q.push_back(0);
    addr_q.push_back(1);
    @(negedge clk);
    eat = 1'b0;
    @(negedge clk);
    cand_x = 5'd20;
    cand_y = 5'd20;
    length = 10'd3;
    repeat (4) begin
      @(negedge clk);
      cand_x = 5'($urandom);
      length = 10'($urandom);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_body_rd", body_rd, 0);
    chk("abort_spawned", spawned, 0);
    chk("abort_fail", fail, 0);
    chk("abort_appleX", appleX, 15);
    chk("abort_appleY", appleY, 15);
    chk("abort_body_addr", body_addr, 0);
    chk("abort_reads", addr_q.size(), 0);
    addr_q.delete();
    model_ax = 15;
    model_ay = 15;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    set_cands(7, 8, 7, 8);
    run_req(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
